// File: rtl/pipeline_exec_ctrl.sv
// Execution controller: sequences PC start/enable/halt from debug-unit commands and counts enabled cycles.
// Optional PC breakpoint support is compiled in with `define EXEC_CTRL_BREAKPOINT_EN.
module pipeline_exec_ctrl #(
   parameter int CNT_W   = 32,
   parameter int PC_SIZE = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
`ifdef EXEC_CTRL_BREAKPOINT_EN
   input  logic [PC_SIZE-1:0] i_pc,
   input  logic [PC_SIZE-1:0] i_bp_addr,
   input  logic             i_bp_en,
`endif
   input  logic             i_cmd_valid,
   input  logic [1:0]       i_cmd,
   output logic             o_cmd_ready,
   input  logic             i_end_program,
   output logic             o_start,
   output logic             o_enable,
   output logic             o_halt,
   output logic             o_done,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic [2:0]       o_state
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_START_RUN  = 3'd1;
   localparam logic [2:0] S_START_STEP = 3'd2;
   localparam logic [2:0] S_RUN        = 3'd3;
   localparam logic [2:0] S_PAUSE      = 3'd4;
   localparam logic [2:0] S_STEP       = 3'd5;
   localparam logic [2:0] S_DONE       = 3'd6;
   localparam logic [2:0] S_HALT       = 3'd7;

   localparam logic [1:0] CMD_RUN   = 2'd0;
   localparam logic [1:0] CMD_STEP  = 2'd1;
   localparam logic [1:0] CMD_STOP  = 2'd2;
   localparam logic [1:0] CMD_CLEAR = 2'd3;

   if (CNT_W < 1 || PC_SIZE < 1) begin : g_param_check
      $error("pipeline_exec_ctrl: CNT_W and PC_SIZE must be at least 1");
   end

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [CNT_W-1:0] count;
   logic             cmd_fire;
   logic             bp_hit;

   assign cmd_fire = i_cmd_valid & o_cmd_ready;

`ifdef EXEC_CTRL_BREAKPOINT_EN
   // Set on the PAUSE->RUN transition so a resumed run can step off the breakpoint PC.
   logic bp_skip;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bp_skip <= 1'b0;
      end else begin
         bp_skip <= (state == S_PAUSE) && (state_next == S_RUN);
      end
   end

   assign bp_hit = i_bp_en && (i_pc == i_bp_addr) && !bp_skip;
`else
   assign bp_hit = 1'b0;
`endif

   // End-of-program always wins; in RUN it beats both STOP and a breakpoint.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (cmd_fire && i_cmd == CMD_RUN) begin
               state_next = S_START_RUN;
            end else if (cmd_fire && i_cmd == CMD_STEP) begin
               state_next = S_START_STEP;
            end
         end
         S_START_RUN:  state_next = i_end_program ? S_DONE : S_RUN;
         S_START_STEP: state_next = i_end_program ? S_DONE : S_PAUSE;
         S_RUN: begin
            if (i_end_program) begin
               state_next = S_DONE;
            end else if (cmd_fire && i_cmd == CMD_STOP) begin
               state_next = S_HALT;
            end else if (bp_hit) begin
               state_next = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (cmd_fire && i_cmd == CMD_STEP) begin
               state_next = S_STEP;
            end else if (cmd_fire && i_cmd == CMD_RUN) begin
               state_next = S_RUN;
            end else if (cmd_fire && i_cmd == CMD_STOP) begin
               state_next = S_HALT;
            end
         end
         S_STEP: state_next = i_end_program ? S_DONE : S_PAUSE;
         S_DONE: begin
            if (cmd_fire && (i_cmd == CMD_CLEAR || i_cmd == CMD_STOP)) begin
               state_next = S_HALT;
            end
         end
         S_HALT:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Cleared on entry to HALT so the counter already reads zero during the halt pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count <= '0;
      end else if (state_next == S_HALT) begin
         count <= '0;
      end else if (o_enable && (count != {CNT_W{1'b1}})) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_start       = (state == S_START_RUN) || (state == S_START_STEP);
   assign o_enable      = (state == S_START_RUN) || (state == S_START_STEP) ||
                          (state == S_RUN)       || (state == S_STEP);
   assign o_halt        = (state == S_HALT);
   assign o_done        = (state == S_DONE);
   assign o_busy        = (state != S_IDLE) && (state != S_DONE);
   assign o_cmd_ready   = (state == S_IDLE) || (state == S_RUN) ||
                          (state == S_PAUSE) || (state == S_DONE);
   assign o_cycle_count = count;
   assign o_state       = state;

endmodule
